rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 35 +++
 rtl/rf_wb_arbiter.sv | 87 ++++++++
 tb/tb_rf_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and requester encoding for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    // Requester index; also the encoding of the round-robin priority pointer.
    typedef enum logic {
        REQ_IDX_0 = 1'b0,   // ALU writeback
        REQ_IDX_1 = 1'b1    // load writeback
    } req_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Outstanding-writeback scoreboard: one busy bit per architectural register.
// A set and a clear to the same register in one cycle leaves it busy.
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NUM_REGS-1:0] busy_nxt;

    // Decode set/clear requests; clear first so a simultaneous set wins. x0 is never busy.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_rd] = 1'b1;
        if (clr_en) clr_vec[clr_rd] = 1'b1;
        busy_nxt    = (busy & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter in front of the register bank write port,
// with an issue/writeback scoreboard. RR_EN=1 selects round-robin, 0 fixed priority.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [REG_ADDR_W-1:0] req0_rd,
    input  logic [XLEN-1:0]       req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REG_ADDR_W-1:0] req1_rd,
    input  logic [XLEN-1:0]       req1_data,
    output logic                  req1_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] a3,
    output logic [XLEN-1:0]       wd3,
    output logic [NUM_REGS-1:0]   busy
);

    req_idx_t              prio;
    logic                  gnt0;
    logic                  gnt1;
    logic                  xfer;
    logic                  wr;
    logic                  issue_set;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    // Grant: a lone valid requester wins; contention goes to the pointer (RR) or req0 (fixed).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((RR_EN != 0) && (prio == REQ_IDX_1)) gnt1 = 1'b1;
            else                                     gnt0 = 1'b1;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign sel_rd     = gnt1 ? req1_rd   : req0_rd;
    assign sel_data   = gnt1 ? req1_data : req0_data;
    assign wr         = xfer && (sel_rd != '0);
    assign issue_set  = issue_valid && (issue_rd != '0);

    // Priority pointer: after a transfer, the other requester gets precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    prio <= REQ_IDX_0;
        else if (xfer) prio <= gnt0 ? REQ_IDX_1 : REQ_IDX_0;
    end

    // Register-bank write port, one cycle behind the accepted transfer; x0 writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we  <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else begin
            we <= wr;
            if (wr) begin
                a3  <= sel_rd;
                wd3 <= sel_data;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (issue_set),
        .set_rd (issue_rd),
        .clr_en (wr),
        .clr_rd (sel_rd),
        .busy   (busy)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: a round-robin and a fixed-priority instance share stimulus
// and are checked against a transaction-level model of grants, writes and busy bits.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, issue_valid;
    logic [4:0]  req0_rd, req1_rd, issue_rd;
    logic [31:0] req0_data, req1_data;

    logic [1:0]       rdy0, rdy1, we_o;
    logic [1:0][4:0]  a3_o;
    logic [1:0][31:0] wd3_o, busy_o;

    int checks   = 0;
    int failures = 0;

    // Model state: index 0 = round-robin instance, 1 = fixed-priority instance.
    int               last_rr;
    logic [1:0][31:0] mbusy;
    logic [1:0]       exp_we;
    logic [1:0][4:0]  exp_a3;
    logic [1:0][31:0] exp_wd3;

    typedef struct {
        logic v0; logic [4:0] rd0; logic [31:0] d0;
        logic v1; logic [4:0] rd1; logic [31:0] d1;
        logic iv; logic [4:0] ird;
        logic [1:0] rdy; logic we; logic [4:0] a3; logic [31:0] wd3; logic [31:0] busy;
    } vec_t;

    vec_t tbl[8];

    rf_wb_arbiter #(.RR_EN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(rdy0[0]),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(rdy1[0]),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .we(we_o[0]), .a3(a3_o[0]), .wd3(wd3_o[0]), .busy(busy_o[0])
    );

    rf_wb_arbiter #(.RR_EN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(rdy0[1]),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(rdy1[1]),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .we(we_o[1]), .a3(a3_o[1]), .wd3(wd3_o[1]), .busy(busy_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Winner under the stated rules: -1 = no transfer.
    function automatic int pick(input bit rr);
        if (req0_valid && req1_valid) return rr ? (1 - last_rr) : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        last_rr = 1;   // as if req1 went last, so req0 holds priority
        mbusy   = '0;
        exp_we  = '0;
        exp_a3  = '0;
        exp_wd3 = '0;
    endtask

    task automatic model_update(input int k, input int g);
        logic [4:0]  rd;
        logic [31:0] d;
        exp_we[k] = 1'b0;
        if (g >= 0) begin
            rd = (g == 1) ? req1_rd   : req0_rd;
            d  = (g == 1) ? req1_data : req0_data;
            if (rd != 0) begin
                exp_we[k]  = 1'b1;
                exp_a3[k]  = rd;
                exp_wd3[k] = d;
                mbusy[k][rd] = 1'b0;
            end
        end
        if (issue_valid && issue_rd != 0) mbusy[k][issue_rd] = 1'b1;
    endtask

    task automatic clear_inputs();
        req0_valid = 0; req0_rd = 0; req0_data = 0;
        req1_valid = 0; req1_rd = 0; req1_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("we[%0d]", k), {31'd0, we_o[k]}, {31'd0, exp_we[k]});
            if (exp_we[k]) begin
                chk($sformatf("a3[%0d]", k), {27'd0, a3_o[k]}, {27'd0, exp_a3[k]});
                chk($sformatf("wd3[%0d]", k), wd3_o[k], exp_wd3[k]);
            end
            chk($sformatf("busy[%0d]", k), busy_o[k], mbusy[k]);
        end
    endtask

    // Inputs are already driven (posedge+1): check readies mid-cycle, clock, check outputs.
    task automatic step(output logic [1:0] grr, output logic [1:0] gfp);
        int wr_, wf;
        #3;
        wr_ = pick(1'b1);
        wf  = pick(1'b0);
        grr = {rdy1[0], rdy0[0]};
        gfp = {rdy1[1], rdy0[1]};
        chk("rr_ready0", {31'd0, rdy0[0]}, {31'd0, (wr_ == 0)});
        chk("rr_ready1", {31'd0, rdy1[0]}, {31'd0, (wr_ == 1)});
        chk("fp_ready0", {31'd0, rdy0[1]}, {31'd0, (wf == 0)});
        chk("fp_ready1", {31'd0, rdy1[1]}, {31'd0, (wf == 1)});
        @(posedge clk);
        model_update(0, wr_);
        model_update(1, wf);
        if (wr_ >= 0) last_rr = wr_;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_we[%0d]", k), {31'd0, we_o[k]}, 32'd0);
            chk($sformatf("rst_a3[%0d]", k), {27'd0, a3_o[k]}, 32'd0);
            chk($sformatf("rst_wd3[%0d]", k), wd3_o[k], 32'd0);
            chk($sformatf("rst_busy[%0d]", k), busy_o[k], 32'd0);
        end
    endtask

    initial begin
        logic [1:0] grr, gfp;
        int wait0, wait1;

        rst_n = 1'b0;
        clear_inputs();
        model_reset();

        // Directed vectors for the round-robin instance, starting from reset.
        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    0, 0, 2'b01, 1, 5, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 0, 32'h0,        1, 0, 32'h1234, 0, 0, 2'b10, 0, 0, 32'h0,        32'h0};
        tbl[2] = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 7, 2'b00, 0, 0, 32'h0,        32'h80};
        tbl[3] = '{1, 7, 32'h77,       0, 0, 32'h0,    0, 0, 2'b01, 1, 7, 32'h77,       32'h0};
        tbl[4] = '{0, 0, 32'h0,        1, 7, 32'h99,   1, 7, 2'b10, 1, 7, 32'h99,       32'h80};
        tbl[5] = '{0, 0, 32'h0,        0, 0, 32'h0,    1, 7, 2'b00, 0, 0, 32'h0,        32'h80};
        tbl[6] = '{1, 3, 32'h30,       1, 4, 32'h40,   0, 0, 2'b01, 1, 3, 32'h30,       32'h80};
        tbl[7] = '{1, 2, 32'h22,       0, 0, 32'h0,    1, 0, 2'b01, 1, 2, 32'h22,       32'h80};

        do_reset();
        foreach (tbl[i]) begin
            req0_valid = tbl[i].v0; req0_rd = tbl[i].rd0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_rd = tbl[i].rd1; req1_data = tbl[i].d1;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
            step(grr, gfp);
            chk($sformatf("tbl%0d_ready", i), {30'd0, grr}, {30'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_we", i), {31'd0, we_o[0]}, {31'd0, tbl[i].we});
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_a3", i), {27'd0, a3_o[0]}, {27'd0, tbl[i].a3});
                chk($sformatf("tbl%0d_wd3", i), wd3_o[0], tbl[i].wd3);
            end
            chk($sformatf("tbl%0d_busy", i), busy_o[0], tbl[i].busy);
        end

        // Contention from reset: RR alternates 0,1,0,1; fixed priority stays on req0.
        do_reset();
        req0_valid = 1; req0_rd = 3; req0_data = 32'hA0;
        req1_valid = 1; req1_rd = 4; req1_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            step(grr, gfp);
            chk($sformatf("rr_seq%0d", i), {30'd0, grr}, (i % 2 == 1) ? 32'd2 : 32'd1);
            chk($sformatf("fp_seq%0d", i), {30'd0, gfp}, 32'd1);
        end

        // Asynchronous reset mid-cycle with busy=0x80, we=1 showing and a transfer pending.
        do_reset();
        req0_valid = 1; req0_rd = 9; req0_data = 32'hA5A5; issue_valid = 1; issue_rd = 7;
        step(grr, gfp);
        clear_inputs();
        req1_valid = 1; req1_rd = 4; req1_data = 32'h4444;
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_busy[%0d]", k), busy_o[k], 32'd0);
            chk($sformatf("arst_we[%0d]", k), {31'd0, we_o[k]}, 32'd0);
            chk($sformatf("arst_a3[%0d]", k), {27'd0, a3_o[k]}, 32'd0);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("arst_lost_we[%0d]", k), {31'd0, we_o[k]}, 32'd0);
        clear_inputs();
        model_reset();
        rst_n = 1'b1;
        step(grr, gfp);

        // Randomised traffic; a requester not granted by the RR instance holds its request.
        do_reset();
        wait0 = 0;
        wait1 = 0;
        for (int n = 0; n < 10000; n++) begin
            if (!(req0_valid && wait0 > 0)) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                req0_data  = $urandom;
            end
            if (!(req1_valid && wait1 > 0)) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                req1_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            step(grr, gfp);
            chk("rr_onehot", {31'd0, grr[0] & grr[1]}, 32'd0);
            chk("fp_onehot", {31'd0, gfp[0] & gfp[1]}, 32'd0);
            if (req0_valid && !grr[0]) begin
                wait0++;
                chk("rr_starve0", wait0, (wait0 > 1) ? 32'd1 : wait0);
            end else begin
                wait0 = 0;
            end
            if (req1_valid && !grr[1]) begin
                wait1++;
                chk("rr_starve1", wait1, (wait1 > 1) ? 32'd1 : wait1);
            end else begin
                wait1 = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
